// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared types, speed encodings and next-address rule for the pattern sequencer
package seq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  localparam logic [1:0] SPD_DIV1 = 2'd0;
  localparam logic [1:0] SPD_DIV2 = 2'd1;
  localparam logic [1:0] SPD_DIV4 = 2'd2;
  localparam logic [1:0] SPD_DIV8 = 2'd3;

  // Ping-pong bounces off the ends instead of wrapping around.
  function automatic int next_addr(input int addr, input int num, input logic up,
                                   input logic pingpong);
    if (up) begin
      if (addr == num - 1) return pingpong ? num - 2 : 0;
      return addr + 1;
    end
    if (addr == 0) return pingpong ? 1 : num - 1;
    return addr - 1;
  endfunction

  function automatic logic next_up(input int addr, input int num, input logic up);
    if (up && addr == num - 1) return 1'b0;
    if (!up && addr == 0) return 1'b1;
    return up;
  endfunction

endpackage

// File: rtl/tick_gen.sv
// rtl/tick_gen.sv - prescaler with speed mask; adv strobes when the masked low bits are all ones
module tick_gen
  import seq_pkg::*;
#(
  parameter int DIV_W = 25
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       clr,
  input  logic [1:0] speed,
  output logic       adv
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] mask;

  always_comb begin
    mask = '1;
    case (speed)
      SPD_DIV1: mask = {DIV_W{1'b1}};
      SPD_DIV2: mask = {DIV_W{1'b1}} >> 1;
      SPD_DIV4: mask = {DIV_W{1'b1}} >> 2;
      SPD_DIV8: mask = {DIV_W{1'b1}} >> 3;
      default:  mask = {DIV_W{1'b1}};
    endcase
  end

  // Mask is applied at compare time so a speed change never disturbs the count.
  assign adv = en && ((cnt & mask) == mask);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + DIV_W'(1);
    end
  end

endmodule

// File: rtl/ptn_seq_ctrl.sv
// rtl/ptn_seq_ctrl.sv - pattern ROM playback controller; SEQ_PINGPONG_EN selects bounce instead of wrap
module ptn_seq_ctrl
  import seq_pkg::*;
#(
  parameter int DIV_W   = 25,
  parameter int PTN_NUM = 24,
  parameter int ADDR_W  = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              btn_run,
  input  logic              btn_step,
  input  logic              btn_clr,
  input  logic              dir,
  input  logic [1:0]        speed,
  output logic [ADDR_W-1:0] ptn_addr,
  output logic              blank,
  output logic              running,
  output logic              tick
);

  state_t            state, state_nx;
  logic              run_q, step_q, clr_q;
  logic              run_ev, step_ev, clr_ev;
  logic              adv_strobe;
  logic              do_adv;
  logic              up_use;
  logic              pingpong;
  logic [ADDR_W-1:0] addr_nx;

  assign run_ev  = btn_run  && !run_q;
  assign step_ev = btn_step && !step_q;
  assign clr_ev  = btn_clr  && !clr_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      run_q  <= 1'b0;
      step_q <= 1'b0;
      clr_q  <= 1'b0;
    end else begin
      run_q  <= btn_run;
      step_q <= btn_step;
      clr_q  <= btn_clr;
    end
  end

  tick_gen #(.DIV_W(DIV_W)) u_tick_gen (
    .clk   (clk),
    .rst   (rst),
    .en    (state == RUN),
    .clr   (state == IDLE),
    .speed (speed),
    .adv   (adv_strobe)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Button events pre-empt a same-cycle advance: clr > run > step/strobe.
  always_comb begin
    state_nx = state;
    do_adv   = 1'b0;
    case (state)
      IDLE: begin
        if (run_ev && !clr_ev) state_nx = RUN;
      end
      RUN: begin
        if (clr_ev)          state_nx = IDLE;
        else if (run_ev)     state_nx = PAUSE;
        else if (adv_strobe) do_adv   = 1'b1;
      end
      PAUSE: begin
        if (clr_ev)       state_nx = IDLE;
        else if (run_ev)  state_nx = RUN;
        else if (step_ev) do_adv   = 1'b1;
      end
      default: state_nx = IDLE;
    endcase
  end

`ifdef SEQ_PINGPONG_EN
  logic up_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      up_q <= 1'b1;
    end else if (state == IDLE && state_nx == RUN) begin
      up_q <= dir;
    end else if (do_adv) begin
      up_q <= next_up(int'(ptn_addr), PTN_NUM, up_q);
    end
  end

  assign up_use   = up_q;
  assign pingpong = 1'b1;
`else
  assign up_use   = dir;
  assign pingpong = 1'b0;
`endif

  assign addr_nx = ADDR_W'(next_addr(int'(ptn_addr), PTN_NUM, up_use, pingpong));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptn_addr <= '0;
      blank    <= 1'b1;
      running  <= 1'b0;
      tick     <= 1'b0;
    end else begin
      if (state_nx == IDLE) ptn_addr <= '0;
      else if (do_adv)      ptn_addr <= addr_nx;
      blank   <= (state_nx == IDLE);
      running <= (state_nx == RUN);
      tick    <= do_adv;
    end
  end

endmodule

// File: doc/ptn_seq_ctrl.md
# ptn_seq_ctrl

Playback controller for the ROM-driven seven-segment pattern display. It replaces the fixed free-running divider/counter pair with a small state machine. The state machine handles start/pause/single-step/clear from board buttons and applies a selectable step rate and direction. It drives the pattern ROM address and a display blank signal consumed by the digit decoders.

## Interface
- DIV_W, 25, prescaler width; slowest step period is 2^DIV_W clocks
- PTN_NUM, 24, number of ROM patterns; legal addresses 0..PTN_NUM-1
- ADDR_W, 5, pattern address width; requires PTN_NUM <= 2^ADDR_W
- clk  input  1  system clock; all state changes on rising edge
- rst  input  1  asynchronous, active-high reset
- btn_run  input  1  level; rising edge toggles start/pause
- btn_step  input  1  level; rising edge advances one pattern while paused
- btn_clr  input  1  level; rising edge returns to IDLE
- dir  input  1  1 = count up, 0 = count down
- speed  input  2  rate select; step period 2^(DIV_W-speed) clocks
- ptn_addr  output  ADDR_W  registered ROM address
- blank  output  1  registered; 1 = decoders drive all segments off
- running  output  1  registered; 1 in RUN
- tick  output  1  registered one-cycle pulse following every address change

## Operation
- Reset values: state IDLE, ptn_addr 0, blank 1, running 0, tick 0, prescaler 0, button history regs 0.
- Edge detect: a button event is current=1 and previous-sample=0 at that clock edge. History regs update every cycle.
- Priority when events coincide: clr > run > step.
- States:
  - IDLE: ptn_addr held at 0, blank 1, prescaler held at 0. Run event goes to RUN. Step is ignored.
  - RUN: prescaler counts every clock. Run event goes to PAUSE. Clr event goes to IDLE and sets ptn_addr to 0. Step is ignored.
  - PAUSE: prescaler held, not cleared. Run event goes to RUN. Step event advances ptn_addr once. Clr event goes to IDLE and sets ptn_addr to 0.
- Advance condition in RUN: prescaler bits [DIV_W-1-speed:0] are all ones.
- Advance rule: up goes +1 with PTN_NUM-1 wrapping to 0. Down goes -1 with 0 wrapping to PTN_NUM-1.
- Address range: ptn_addr never leaves 0..PTN_NUM-1.
- Speed change mid-RUN: takes effect on the next compare; the prescaler is not cleared.
- dir: sampled at each advance.

## Timing
- Entering RUN from IDLE:
  - prescaler is 0 on the first RUN cycle;
  - blank falls and running rises on the same edge as the state change;
  - first advance occurs 2^(DIV_W-speed) clocks after entry.
- Advance edge: ptn_addr updates on it; tick is high for exactly the following cycle.
- Step in PAUSE: ptn_addr updates on the edge that detects the step event; tick follows one cycle later.
- Reset mid-operation: all outputs return to their reset values immediately, with no clock required.
- Button held high: produces a single event until it is released.

## Configuration
- SEQ_PINGPONG_EN defined:
  - an internal direction register is loaded from dir on entry to RUN from IDLE;
  - at PTN_NUM-1 going up, the next address is PTN_NUM-2 and direction flips to down;
  - at 0 going down, the next address is 1 and direction flips to up;
  - dir is ignored afterwards until IDLE;
  - steps in PAUSE use and flip the same register.
- SEQ_PINGPONG_EN undefined: wrap-around as in Operation.

## Structure
- Package seq_pkg holds:
  - state enum: IDLE, RUN, PAUSE;
  - speed encodings SPD_DIV1..SPD_DIV8;
  - shared next-address function (wrap / ping-pong).
- Sub-module tick_gen: prescaler with speed mask, enable and clear; outputs the advance strobe.
- Edge detection and the FSM stay in ptn_seq_ctrl.

## Test plan
All scenarios use DIV_W=4, PTN_NUM=24.
- Reset: assert rst mid-RUN -> ptn_addr 0, blank 1, running 0, tick 0 with no clock edge.
- Rate and wrap: run edge, speed=0, dir=1 -> first advance 16 clocks after entry; after 24 advances ptn_addr has gone 23->0; tick pulses once per advance.
- Speed: speed=3 -> advances every 2 clocks; down wrap shows 0->23 with dir=0.
- Pause/step: run, run (PAUSE), 3 step edges with btn_step held 5 cycles each -> ptn_addr +3 exactly; held button gives one step.
- Priority: btn_clr and btn_run rise on the same edge in RUN -> state IDLE, ptn_addr 0, blank 1.
- Ping-pong (SEQ_PINGPONG_EN): speed=3, dir=1 -> sequence 22,23,22,21; and from 0 going down -> 1.
